mem_bus_arbiter: RTL and testbench

Arbitrates the single system memory bus (MAB, MDBout, BW, MW) between the CPU's system bus control path and a DMA requester. The CPU normally owns the bus. The DMA gets the bus only at instruction boundaries, in bounded bursts, with an enforced CPU cool-down afterwards. The block sits between the CPU bus-control outputs and memory/peripherals, and it stalls the CPU with cpu_hold while the DMA owns the bus.

---
 rtl/mem_bus_arbiter_pkg.sv | 26 ++
 rtl/mem_bus_arbiter_if.sv | 36 +++
 rtl/mem_bus_arbiter_bus_mux.sv | 31 +++
 rtl/mem_bus_arbiter.sv | 101 ++++++++++
 tb/tb_mem_bus_arbiter.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types and constants for the memory bus arbiter: FSM state encoding,
// bus beat struct and address/data masks.
package mem_bus_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_S_CPU  = 2'd0,
        ARB_S_DMA  = 2'd1,
        ARB_S_COOL = 2'd2
    } arb_state_t;

    localparam logic [15:0] ARB_BYTE_MASK      = 16'h00FF;
    localparam logic [15:0] ARB_WORD_ADDR_MASK = 16'hFFFE;

    typedef struct packed {
        logic [15:0] addr;
        logic [15:0] data;
        logic        bw;
        logic        mw;
    } arb_bus_t;

    // Terminal count for an 8-bit up-counter that must run n cycles.
    function automatic logic [7:0] arb_last(input int unsigned n);
        return 8'(n - 1);
    endfunction

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Bus bundle between the CPU / DMA requesters, the arbiter and memory.
// master = arbiter view, slave = system (requesters + memory) view.
interface mem_bus_arbiter_if;
    logic [15:0] cpu_mab;
    logic [15:0] cpu_mdbout;
    logic        cpu_bw;
    logic        cpu_mw;
    logic        cpu_busreq;
    logic        cpu_ibound;
    logic        cpu_intack;
    logic        irq_pend;
    logic        dma_req;
    logic [15:0] dma_addr;
    logic [15:0] dma_dout;
    logic        dma_bw;
    logic        dma_mw;
    logic [15:0] MAB;
    logic [15:0] MDBout;
    logic        BW;
    logic        MW;
    logic        cpu_hold;
    logic        dma_ack;
    logic        dma_gnt;

    modport master (
        input  cpu_mab, cpu_mdbout, cpu_bw, cpu_mw, cpu_busreq, cpu_ibound,
               cpu_intack, irq_pend, dma_req, dma_addr, dma_dout, dma_bw, dma_mw,
        output MAB, MDBout, BW, MW, cpu_hold, dma_ack, dma_gnt
    );

    modport slave (
        output cpu_mab, cpu_mdbout, cpu_bw, cpu_mw, cpu_busreq, cpu_ibound,
               cpu_intack, irq_pend, dma_req, dma_addr, dma_dout, dma_bw, dma_mw,
        input  MAB, MDBout, BW, MW, cpu_hold, dma_ack, dma_gnt
    );
endinterface

// File: rtl/mem_bus_arbiter_bus_mux.sv
// bus_mux_16: combinational CPU/DMA bus select. DMA word accesses are forced
// to even addresses; DMA write data is zeroed on reads and byte-masked on byte writes.
module bus_mux_16
    import mem_bus_arbiter_pkg::*;
(
    input  logic     i_sel_dma,
    input  logic     i_dma_req,
    input  arb_bus_t i_cpu,
    input  arb_bus_t i_dma,
    output arb_bus_t o_bus
);

    logic     w_dma_mw;
    arb_bus_t w_dma_bus;

    always_comb begin
        w_dma_mw       = i_dma.mw & i_dma_req;
        w_dma_bus.bw   = i_dma.bw;
        w_dma_bus.mw   = w_dma_mw;
        w_dma_bus.addr = i_dma.bw ? i_dma.addr : (i_dma.addr & ARB_WORD_ADDR_MASK);
        if (!w_dma_mw)
            w_dma_bus.data = 16'h0000;
        else if (i_dma.bw)
            w_dma_bus.data = i_dma.data & ARB_BYTE_MASK;
        else
            w_dma_bus.data = i_dma.data;
    end

    assign o_bus = i_sel_dma ? w_dma_bus : i_cpu;

endmodule

// File: rtl/mem_bus_arbiter.sv
// CPU/DMA memory bus arbiter: DMA is granted only at instruction boundaries or
// idle CPU cycles, in bursts of at most BURST_MAX, with a CPU cool-down afterwards.
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int unsigned BURST_MAX   = 4,
    parameter int unsigned COOL_CYCLES = 1
) (
    input  logic               clk,
    input  logic               rst,
    mem_bus_arbiter_if.master  bus
);

    localparam logic [7:0] LP_BURST_LAST = arb_last(BURST_MAX);
    localparam logic [7:0] LP_COOL_LAST  = arb_last(COOL_CYCLES);

    arb_state_t r_state, w_state_nxt;
    logic [7:0] r_burst_cnt, w_burst_nxt;
    logic [7:0] r_cool_cnt, w_cool_nxt;
    logic       r_hold;
    logic       w_grant;
    logic       w_gnt;
    logic       w_ack;
    arb_bus_t   w_cpu_bus, w_dma_bus, w_out_bus;

    // DMA may only take the bus where the CPU's current access is its last or it has none.
    assign w_grant = bus.dma_req & ~bus.cpu_intack & ~bus.irq_pend
                   & (bus.cpu_ibound | ~bus.cpu_busreq);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ARB_S_CPU;
            r_burst_cnt <= 8'd0;
            r_cool_cnt  <= 8'd0;
            r_hold      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_burst_cnt <= w_burst_nxt;
            r_cool_cnt  <= w_cool_nxt;
            r_hold      <= (w_state_nxt == ARB_S_DMA);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_burst_nxt = r_burst_cnt;
        w_cool_nxt  = r_cool_cnt;
        case (r_state)
            ARB_S_CPU: begin
                if (w_grant) begin
                    w_state_nxt = ARB_S_DMA;
                    w_burst_nxt = 8'd0;
                end
            end
            ARB_S_DMA: begin
                // dma_req low wins over the burst limit: release without cool-down.
                if (!bus.dma_req) begin
                    w_state_nxt = ARB_S_CPU;
                end else begin
                    w_burst_nxt = r_burst_cnt + 8'd1;
                    if ((r_burst_cnt == LP_BURST_LAST) || bus.irq_pend) begin
                        w_state_nxt = ARB_S_COOL;
                        w_cool_nxt  = 8'd0;
                    end
                end
            end
            ARB_S_COOL: begin
                if (r_cool_cnt == LP_COOL_LAST)
                    w_state_nxt = ARB_S_CPU;
                else
                    w_cool_nxt = r_cool_cnt + 8'd1;
            end
            default: w_state_nxt = ARB_S_CPU;
        endcase
    end

    always_comb begin
        w_gnt = (r_state == ARB_S_DMA);
        w_ack = w_gnt & bus.dma_req;
    end

    assign w_cpu_bus = '{addr: bus.cpu_mab, data: bus.cpu_mdbout, bw: bus.cpu_bw, mw: bus.cpu_mw};
    assign w_dma_bus = '{addr: bus.dma_addr, data: bus.dma_dout, bw: bus.dma_bw, mw: bus.dma_mw};

    bus_mux_16 u_mux (
        .i_sel_dma (w_gnt),
        .i_dma_req (bus.dma_req),
        .i_cpu     (w_cpu_bus),
        .i_dma     (w_dma_bus),
        .o_bus     (w_out_bus)
    );

    assign bus.MAB      = w_out_bus.addr;
    assign bus.MDBout   = w_out_bus.data;
    assign bus.BW       = w_out_bus.bw;
    assign bus.MW       = w_out_bus.mw;
    assign bus.cpu_hold = r_hold;
    assign bus.dma_gnt  = w_gnt;
    assign bus.dma_ack  = w_ack;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: directed scenarios plus a randomized
// run against a cycle-level ownership model.
module tb_mem_bus_arbiter;

    localparam int BMAX = 4;
    localparam int COOL = 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_bus_arbiter_if bus_if();

    mem_bus_arbiter #(.BURST_MAX(BMAX), .COOL_CYCLES(COOL)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: who owns the bus, transfers done in this grant, cool cycles left.
    bit m_dma;
    int m_xfers;
    int m_cool_left;

    task automatic model_reset();
        m_dma = 0; m_xfers = 0; m_cool_left = 0;
    endtask

    // Advance one clock: derive next ownership from the inputs held this cycle.
    task automatic tick();
        bit g, nd;
        int nx, nc;
        g  = bus_if.dma_req && !bus_if.cpu_intack && !bus_if.irq_pend &&
             (bus_if.cpu_ibound || !bus_if.cpu_busreq);
        nd = m_dma; nx = m_xfers; nc = m_cool_left;
        if (m_dma) begin
            if (!bus_if.dma_req) nd = 0;
            else begin
                nx = m_xfers + 1;
                if (nx >= BMAX || bus_if.irq_pend) begin nd = 0; nc = COOL; end
            end
        end else if (m_cool_left > 0) begin
            nc = m_cool_left - 1;
        end else if (g) begin
            nd = 1; nx = 0;
        end
        @(posedge clk);
        m_dma = nd; m_xfers = nx; m_cool_left = nc;
        @(negedge clk);
    endtask

    function automatic logic [38:0] model_out();
        logic [15:0] mab, mdb;
        logic bw, mw;
        if (m_dma) begin
            bw  = bus_if.dma_bw;
            mw  = bus_if.dma_mw && bus_if.dma_req;
            mab = bus_if.dma_bw ? bus_if.dma_addr : bus_if.dma_addr - (bus_if.dma_addr % 2);
            mdb = !mw ? 16'd0 : (bus_if.dma_bw ? bus_if.dma_dout % 256 : bus_if.dma_dout);
        end else begin
            bw = bus_if.cpu_bw; mw = bus_if.cpu_mw; mab = bus_if.cpu_mab; mdb = bus_if.cpu_mdbout;
        end
        return {mab, mdb, bw, mw, m_dma, m_dma && bus_if.dma_req, m_dma};
    endfunction

    task automatic idle();
        bus_if.cpu_mab = 16'h1234; bus_if.cpu_mdbout = 16'h0000;
        bus_if.cpu_bw = 0; bus_if.cpu_mw = 0; bus_if.cpu_busreq = 1;
        bus_if.cpu_ibound = 0; bus_if.cpu_intack = 0; bus_if.irq_pend = 0;
        bus_if.dma_req = 0; bus_if.dma_addr = 16'h0000; bus_if.dma_dout = 16'h0000;
        bus_if.dma_bw = 0; bus_if.dma_mw = 0;
    endtask

    task automatic test_reset();
        rst = 1; idle();
        bus_if.dma_req = 1; bus_if.cpu_ibound = 1;
        @(negedge clk); #1;
        n_tests++; if (bus_if.dma_gnt !== 1'b0) begin n_fail++; $display("FAIL rst_gnt: got %b want 0", bus_if.dma_gnt); end
        n_tests++; if (bus_if.dma_ack !== 1'b0) begin n_fail++; $display("FAIL rst_ack: got %b want 0", bus_if.dma_ack); end
        n_tests++; if (bus_if.cpu_hold !== 1'b0) begin n_fail++; $display("FAIL rst_hold: got %b want 0", bus_if.cpu_hold); end
        n_tests++; if (bus_if.MAB !== 16'h1234) begin n_fail++; $display("FAIL rst_mab: got %h want 1234", bus_if.MAB); end
        @(negedge clk);
        rst = 0; model_reset();
        tick();
        bus_if.dma_mw = 1; bus_if.dma_addr = 16'h0400;
        #1;
        n_tests++; if (bus_if.MW !== 1'b1) begin n_fail++; $display("FAIL rst_pre_mw: got %b want 1", bus_if.MW); end
        #1 rst = 1;
        #1;
        n_tests++; if (bus_if.MW !== 1'b0) begin n_fail++; $display("FAIL rst_mid_mw: got %b want 0", bus_if.MW); end
        n_tests++; if (bus_if.dma_gnt !== 1'b0) begin n_fail++; $display("FAIL rst_mid_gnt: got %b want 0", bus_if.dma_gnt); end
        n_tests++; if (bus_if.cpu_hold !== 1'b0) begin n_fail++; $display("FAIL rst_mid_hold: got %b want 0", bus_if.cpu_hold); end
        n_tests++; if (bus_if.dma_ack !== 1'b0) begin n_fail++; $display("FAIL rst_mid_ack: got %b want 0", bus_if.dma_ack); end
        n_tests++; if (bus_if.MAB !== 16'h1234) begin n_fail++; $display("FAIL rst_mid_mab: got %h want 1234", bus_if.MAB); end
        model_reset();
        bus_if.dma_req = 0;
        @(negedge clk);
        rst = 0;
    endtask

    task automatic test_grant_boundary();
        idle();
        bus_if.cpu_mab = 16'h1111; bus_if.dma_req = 1;
        bus_if.dma_addr = 16'h0201; bus_if.dma_bw = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_tests++; if (bus_if.dma_gnt !== 1'b0) begin n_fail++; $display("FAIL gb_nogrant%0d: got %b want 0", i, bus_if.dma_gnt); end
            tick();
        end
        bus_if.cpu_ibound = 1;
        #1;
        n_tests++; if (bus_if.MAB !== 16'h1111) begin n_fail++; $display("FAIL gb_last_cpu_mab: got %h want 1111", bus_if.MAB); end
        tick();
        bus_if.cpu_ibound = 0;
        #1;
        n_tests++; if (bus_if.dma_gnt !== 1'b1) begin n_fail++; $display("FAIL gb_gnt: got %b want 1", bus_if.dma_gnt); end
        n_tests++; if (bus_if.cpu_hold !== 1'b1) begin n_fail++; $display("FAIL gb_hold: got %b want 1", bus_if.cpu_hold); end
        n_tests++; if (bus_if.MAB !== 16'h0200) begin n_fail++; $display("FAIL gb_mab: got %h want 0200", bus_if.MAB); end
        bus_if.dma_req = 0;
        tick();
        #1;
        n_tests++; if (bus_if.dma_gnt !== 1'b0) begin n_fail++; $display("FAIL gb_release: got %b want 0", bus_if.dma_gnt); end
    endtask

    task automatic test_burst_limit();
        bit exp_g [8];
        int acks;
        exp_g = '{0, 1, 1, 1, 1, 0, 0, 1};
        acks = 0;
        idle();
        bus_if.dma_req = 1; bus_if.cpu_ibound = 1; bus_if.dma_mw = 1;
        bus_if.dma_addr = 16'h0010; bus_if.dma_dout = 16'h5555;
        for (int i = 0; i < 8; i++) begin
            #1;
            n_tests++; if (bus_if.dma_gnt !== exp_g[i]) begin n_fail++; $display("FAIL bl_gnt%0d: got %b want %b", i, bus_if.dma_gnt, exp_g[i]); end
            n_tests++; if (bus_if.cpu_hold !== exp_g[i]) begin n_fail++; $display("FAIL bl_hold%0d: got %b want %b", i, bus_if.cpu_hold, exp_g[i]); end
            if (i < 7 && bus_if.dma_ack === 1'b1) acks++;
            tick();
        end
        n_tests++; if (acks != BMAX) begin n_fail++; $display("FAIL bl_acks: got %0d want %0d", acks, BMAX); end
        bus_if.dma_req = 0;
        tick();
    endtask

    task automatic test_byte_write();
        idle();
        bus_if.dma_req = 1; bus_if.cpu_ibound = 1;
        tick();
        bus_if.dma_bw = 1; bus_if.dma_mw = 1; bus_if.dma_dout = 16'hABCD; bus_if.dma_addr = 16'h0301;
        #1;
        n_tests++; if (bus_if.MAB !== 16'h0301) begin n_fail++; $display("FAIL bw_mab: got %h want 0301", bus_if.MAB); end
        n_tests++; if (bus_if.MDBout !== 16'h00CD) begin n_fail++; $display("FAIL bw_mdb: got %h want 00cd", bus_if.MDBout); end
        n_tests++; if (bus_if.BW !== 1'b1) begin n_fail++; $display("FAIL bw_bw: got %b want 1", bus_if.BW); end
        n_tests++; if (bus_if.MW !== 1'b1) begin n_fail++; $display("FAIL bw_mw: got %b want 1", bus_if.MW); end
        tick();
        bus_if.dma_bw = 0;
        #1;
        n_tests++; if (bus_if.MAB !== 16'h0300) begin n_fail++; $display("FAIL ww_mab: got %h want 0300", bus_if.MAB); end
        n_tests++; if (bus_if.MDBout !== 16'hABCD) begin n_fail++; $display("FAIL ww_mdb: got %h want abcd", bus_if.MDBout); end
        bus_if.dma_mw = 0;
        #1;
        n_tests++; if (bus_if.MDBout !== 16'h0000) begin n_fail++; $display("FAIL rd_mdb: got %h want 0000", bus_if.MDBout); end
        bus_if.dma_req = 0;
        tick();
    endtask

    task automatic test_irq_preempt();
        idle();
        bus_if.dma_req = 1; bus_if.cpu_ibound = 1;
        tick();
        #1;
        n_tests++; if (bus_if.dma_ack !== 1'b1) begin n_fail++; $display("FAIL irq_ack1: got %b want 1", bus_if.dma_ack); end
        tick();
        bus_if.irq_pend = 1;
        #1;
        n_tests++; if (bus_if.dma_ack !== 1'b1) begin n_fail++; $display("FAIL irq_ack2: got %b want 1", bus_if.dma_ack); end
        tick();
        #1;
        n_tests++; if (bus_if.dma_gnt !== 1'b0) begin n_fail++; $display("FAIL irq_cool_gnt: got %b want 0", bus_if.dma_gnt); end
        n_tests++; if (bus_if.cpu_hold !== 1'b0) begin n_fail++; $display("FAIL irq_cool_hold: got %b want 0", bus_if.cpu_hold); end
        tick();
        for (int i = 0; i < 3; i++) begin
            #1;
            n_tests++; if (bus_if.dma_gnt !== 1'b0) begin n_fail++; $display("FAIL irq_block%0d: got %b want 0", i, bus_if.dma_gnt); end
            tick();
        end
        bus_if.irq_pend = 0; bus_if.cpu_intack = 1;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_tests++; if (bus_if.dma_gnt !== 1'b0) begin n_fail++; $display("FAIL intack_block%0d: got %b want 0", i, bus_if.dma_gnt); end
            tick();
        end
        bus_if.cpu_intack = 0;
        tick();
        #1;
        n_tests++; if (bus_if.dma_gnt !== 1'b1) begin n_fail++; $display("FAIL irq_regrant: got %b want 1", bus_if.dma_gnt); end
        bus_if.dma_req = 0;
        tick();
    endtask

    task automatic test_early_release();
        idle();
        bus_if.cpu_mab = 16'hBEEF; bus_if.cpu_mw = 1; bus_if.cpu_mdbout = 16'h1357;
        bus_if.dma_req = 1; bus_if.cpu_ibound = 1; bus_if.dma_mw = 1; bus_if.dma_addr = 16'h0800;
        tick();
        for (int i = 0; i < 2; i++) begin
            #1;
            n_tests++; if (bus_if.dma_ack !== 1'b1) begin n_fail++; $display("FAIL er_ack%0d: got %b want 1", i, bus_if.dma_ack); end
            tick();
        end
        bus_if.dma_req = 0;
        #1;
        n_tests++; if (bus_if.MW !== 1'b0) begin n_fail++; $display("FAIL er_mw_drop: got %b want 0", bus_if.MW); end
        n_tests++; if (bus_if.dma_ack !== 1'b0) begin n_fail++; $display("FAIL er_noack: got %b want 0", bus_if.dma_ack); end
        tick();
        #1;
        n_tests++; if (bus_if.dma_gnt !== 1'b0) begin n_fail++; $display("FAIL er_gnt: got %b want 0", bus_if.dma_gnt); end
        n_tests++; if (bus_if.MAB !== 16'hBEEF) begin n_fail++; $display("FAIL er_mab: got %h want beef", bus_if.MAB); end
        n_tests++; if (bus_if.MW !== 1'b1) begin n_fail++; $display("FAIL er_cpu_mw: got %b want 1", bus_if.MW); end
        n_tests++; if (bus_if.MDBout !== 16'h1357) begin n_fail++; $display("FAIL er_mdb: got %h want 1357", bus_if.MDBout); end
        bus_if.dma_req = 1;
        tick();
        #1;
        n_tests++; if (bus_if.dma_gnt !== 1'b1) begin n_fail++; $display("FAIL er_no_cool: got %b want 1", bus_if.dma_gnt); end
        bus_if.dma_req = 0;
        tick();
    endtask

    task automatic test_random();
        logic [38:0] exp_v, got_v;
        for (int i = 0; i < 400; i++) begin
            bus_if.dma_req    = ($urandom_range(0, 9) < 7);
            bus_if.irq_pend   = ($urandom_range(0, 9) == 0);
            bus_if.cpu_intack = ($urandom_range(0, 9) == 0);
            bus_if.cpu_ibound = ($urandom_range(0, 9) < 4);
            bus_if.cpu_busreq = ($urandom_range(0, 9) < 7);
            bus_if.cpu_mab    = 16'($urandom); bus_if.cpu_mdbout = 16'($urandom);
            bus_if.cpu_bw     = 1'($urandom); bus_if.cpu_mw = 1'($urandom);
            bus_if.dma_addr   = 16'($urandom); bus_if.dma_dout = 16'($urandom);
            bus_if.dma_bw     = 1'($urandom); bus_if.dma_mw = 1'($urandom);
            #1;
            exp_v = model_out();
            got_v = {bus_if.MAB, bus_if.MDBout, bus_if.BW, bus_if.MW,
                     bus_if.dma_gnt, bus_if.dma_ack, bus_if.cpu_hold};
            n_tests++;
            if (got_v !== exp_v) begin
                n_fail++;
                $display("FAIL rand%0d {MAB,MDB,BW,MW,GNT,ACK,HOLD}: got %h want %h", i, got_v, exp_v);
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_grant_boundary();
        test_burst_limit();
        test_byte_write();
        test_irq_preempt();
        test_early_release();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
